alu_exec_unit: RTL
==================

# alu_exec_unit

Parametrised execute-stage unit for the RV32 pipeline: decodes ALUOp/Funct3/Funct7 and computes the result of base-integer ALU ops in one cycle, plus RV32M multiply/divide through an iterative engine. It replaces the stand-alone ALU control/ALU pair in EX. A valid/ready handshake lets the hazard unit stall IF/ID while a multi-cycle op runs, and a flush input aborts work on a branch mispredict.

## Interface
- XLEN, 32: operand/result width; must be ≥ 8 and a power of two.
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- valid_i  in  1  operation presented this cycle
- ready_o  out  1  unit can accept; high only in state IDLE
- ALUOp_i  in  2  00 R-type, 01 load/store add, 10 LUI pass-B, 11 I-type
- Funct3_i  in  3  instruction funct3
- Funct7_i  in  7  instruction funct7, with immediate[11:5] for I-type
- OperandA_i  in  XLEN  rs1 value
- OperandB_i  in  XLEN  rs2 value or immediate
- flush_i  in  1  abort current and presented op
- result_o  out  XLEN  registered result
- valid_o  out  1  one-cycle pulse; result_o is valid

## Operation
- Accept on a rising edge with valid_i & ready_o & !flush_i.
- ALUOp 00, funct7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND by funct3.
- ALUOp 00, funct7 0100000: SUB for funct3 000, SRA for funct3 101.
- ALUOp 01: ADD.
- ALUOp 10: result = OperandB_i.
- ALUOp 11: same ops by funct3.
  - Funct7_i[5] selects SRA over SRL for funct3 101.
  - Funct7_i is ignored for funct3 000, which is always ADD.
- Shifts use OperandB_i[$clog2(XLEN)-1:0]. SLT/SLTU results are zero-extended to 1.
- Any unlisted combination computes AND in a single cycle.
- ALUOp 00 with funct7 0000001 selects the M-extension ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3.
  - Multiply: shift-add, one bit per cycle, 2·XLEN product. MULH treats both operands signed; MULHSU treats rs1 signed and rs2 unsigned.
  - Divide: restoring divide, one bit per cycle, on magnitudes, with quotient and remainder signs fixed at completion.
  - Remainder sign follows the dividend.
- Division special cases complete in a single cycle and skip the FSM:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (−2^(XLEN−1) ÷ −1): DIV gives the dividend; REM gives 0.
- FSM states and transitions:
  - IDLE → MUL or DIV on accepting an M op. Counter loads XLEN−1.
  - MUL/DIV: one iteration per cycle, counter decrements. At counter 0, go to IDLE and set valid_o.
  - Any state → IDLE on flush_i, with no valid_o.

## Timing
- Reset values: result_o 0, valid_o 0, state IDLE (so ready_o 1), counter 0, engine registers 0. Reset during MUL/DIV drops the op immediately.
- Single-cycle op accepted at edge N: valid_o is high in cycle N+1. Back-to-back accepts every cycle are allowed.
- M op accepted at edge N:
  - ready_o is low for cycles N+1 … N+XLEN.
  - valid_o is high in cycle N+XLEN+1, with ready_o already high, so a new op can be accepted on that edge.
- flush_i in cycle N: state is IDLE and valid_o is 0 in cycle N+1. An op presented with flush_i is discarded.
- result_o holds its last value when valid_o is 0.

## Configuration
- ALU_MEXT_EN defined: M-extension decode, FSM and the iterative engine are compiled in.
- ALU_MEXT_EN undefined:
  - funct7 0000001 falls to the unlisted default (AND, single cycle).
  - The FSM reduces to IDLE, so ready_o is tied to 1.
  - No engine is instantiated.

## Structure
- Package alu_pkg holds:
  - ALUOp encodings (ALUOP_R, ALUOP_MEM, ALUOP_LUI, ALUOP_I)
  - the 5-bit ALU control enum
  - FUNCT7 constants (BASE 0000000, ALT 0100000, MEXT 0000001)
  - the FSM state typedef (IDLE, MUL, DIV)
- Sub-module alu_muldiv_seq contains:
  - the iterative multiply/divide datapath, counter and sign fix-up
  - a start/done handshake toward alu_exec_unit
- alu_exec_unit keeps the decode, the single-cycle ALU, the special-case divide and the output register.

## Test plan
- XLEN=32, ALUOp 11, funct3 101, Funct7 0100000, A=0x80000000, B=4 → valid_o at N+1, result 0xF8000000 (SRAI).
- ALUOp 00 MUL, A=0xFFFFFFFF (−1), B=7:
  - MUL → 0xFFFFFFF9, with ready_o low for 32 cycles and valid_o at N+33.
  - MULHU with the same operands → 0x00000006.
- DIV, A=−7, B=2 → quotient 0xFFFFFFFD (−3); REM with the same operands → 0xFFFFFFFF (−1); both at N+33.
- DIVU with B=0 → 0xFFFFFFFF at N+1. DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000 at N+1.
- flush_i asserted 10 cycles into a DIV → cycle after: ready_o 1, no valid_o pulse. A following ADD 3+4 → 7 at the next cycle.
- rst_ni pulled low mid-MULH → result_o 0, valid_o 0, ready_o 1 immediately. Rerun the build without ALU_MEXT_EN: MUL 6×7 → result 6 AND 7 = 6 at N+1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: ALUOp values, funct7 classes,
// the internal ALU control enum, the M-extension FSM states and decode helpers.
package alu_pkg;

   localparam logic [1:0] ALUOP_R   = 2'b00;
   localparam logic [1:0] ALUOP_MEM = 2'b01;
   localparam logic [1:0] ALUOP_LUI = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
   localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_PASSB,
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV
   } alu_state_e;

   // Base integer op by funct3; use_sra picks SRA over SRL for funct3 101.
   function automatic alu_ctrl_e base_op(input logic [2:0] f3, input logic use_sra);
      alu_ctrl_e r;
      r = ALU_AND;
      case (f3)
         3'b000:  r = ALU_ADD;
         3'b001:  r = ALU_SLL;
         3'b010:  r = ALU_SLT;
         3'b011:  r = ALU_SLTU;
         3'b100:  r = ALU_XOR;
         3'b101:  r = use_sra ? ALU_SRA : ALU_SRL;
         3'b110:  r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

   // M-extension op by funct3.
   function automatic alu_ctrl_e mext_op(input logic [2:0] f3);
      alu_ctrl_e r;
      r = ALU_MUL;
      case (f3)
         3'b000:  r = ALU_MUL;
         3'b001:  r = ALU_MULH;
         3'b010:  r = ALU_MULHSU;
         3'b011:  r = ALU_MULHU;
         3'b100:  r = ALU_DIV;
         3'b101:  r = ALU_DIVU;
         3'b110:  r = ALU_REM;
         default: r = ALU_REMU;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up on the final step.
// Only compiled when ALU_MEXT_EN is defined.
`ifdef ALU_MEXT_EN
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            run_i,
   input  alu_ctrl_e       op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_c,
   output logic [XLEN-1:0] result_c
);

   localparam int unsigned CW = $clog2(XLEN);

   // hi holds product-high / remainder, lo holds multiplier / quotient
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic            is_div_q, is_div_d, sel_hi_q, sel_hi_d;
   logic            neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

   logic            a_sgn, b_sgn, a_neg, b_neg, st_div, st_hi;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic [XLEN-1:0] hi_n, lo_n, q_fix, r_fix;
   logic [2*XLEN-1:0] prod_fix;
   logic            q_bit;

   // Classify the starting op and take operand magnitudes
   always_comb begin
      a_sgn  = 1'b0;
      b_sgn  = 1'b0;
      st_div = 1'b0;
      st_hi  = 1'b0;
      case (op_i)
         ALU_MULH:   begin a_sgn = 1'b1; b_sgn = 1'b1; st_hi = 1'b1; end
         ALU_MULHSU: begin a_sgn = 1'b1; st_hi = 1'b1; end
         ALU_MULHU:  st_hi = 1'b1;
         ALU_DIV:    begin a_sgn = 1'b1; b_sgn = 1'b1; st_div = 1'b1; end
         ALU_DIVU:   st_div = 1'b1;
         ALU_REM:    begin a_sgn = 1'b1; b_sgn = 1'b1; st_div = 1'b1; st_hi = 1'b1; end
         ALU_REMU:   begin st_div = 1'b1; st_hi = 1'b1; end
         default:    ;
      endcase
      a_neg = a_sgn & a_i[XLEN-1];
      b_neg = b_sgn & b_i[XLEN-1];
      mag_a = a_neg ? -a_i : a_i;
      mag_b = b_neg ? -b_i : b_i;
   end

   // One multiply or divide iteration, plus the sign-fixed result of that step
   always_comb begin
      mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      q_bit     = ~div_diff[XLEN];
      if (is_div_q) begin
         hi_n = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], q_bit};
      end else begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      prod_fix = neg_lo_q ? -{hi_n, lo_n} : {hi_n, lo_n};
      q_fix    = neg_lo_q ? -lo_n : lo_n;
      r_fix    = neg_hi_q ? -hi_n : hi_n;
      if (is_div_q) result_c = sel_hi_q ? r_fix : q_fix;
      else          result_c = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
      done_c = run_i && (cnt_q == '0);
   end

   // Next-state for the engine registers: load on start, iterate while running
   always_comb begin
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      sel_hi_d = sel_hi_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      if (start_i) begin
         cnt_d    = CW'(XLEN - 1);
         hi_d     = '0;
         lo_d     = st_div ? mag_a : mag_b;
         opnd_d   = st_div ? mag_b : mag_a;
         is_div_d = st_div;
         sel_hi_d = st_hi;
         neg_lo_d = a_neg ^ b_neg;
         neg_hi_d = a_neg;
      end else if (run_i) begin
         hi_d = hi_n;
         lo_d = lo_n;
         if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
   end

   // Engine state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         sel_hi_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         sel_hi_q <= sel_hi_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
      end
   end

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// RV32 execute-stage unit: ALU decode, single-cycle integer ALU, divide special
// cases and registered result. Define ALU_MEXT_EN to add the M-extension FSM
// and iterative engine; without it ready_o is tied high.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [1:0]      ALUOp_i,
   input  logic [2:0]      Funct3_i,
   input  logic [6:0]      Funct7_i,
   input  logic [XLEN-1:0] OperandA_i,
   input  logic [XLEN-1:0] OperandB_i,
   input  logic            flush_i,
   output logic [XLEN-1:0] result_o,
   output logic            valid_o
);

   localparam int unsigned SHW = $clog2(XLEN);

   alu_ctrl_e       ctrl_c;
   logic [SHW-1:0]  shamt_c;
   logic [XLEN-1:0] alu_res_c, one_res_c, eng_res_c;
   logic            accept_c, single_c, eng_fire_c;
   logic [XLEN-1:0] result_q, result_d;
   logic            valid_q, valid_d;

   assign accept_c = valid_i & ready_o & ~flush_i;
   assign shamt_c  = OperandB_i[SHW-1:0];

   // Decode ALUOp/funct3/funct7 into an ALU control code
   always_comb begin
      ctrl_c = ALU_AND;
      case (ALUOp_i)
         ALUOP_R: begin
            if (Funct7_i == FUNCT7_BASE) begin
               ctrl_c = base_op(Funct3_i, 1'b0);
            end else if (Funct7_i == FUNCT7_ALT) begin
               if (Funct3_i == 3'b000)      ctrl_c = ALU_SUB;
               else if (Funct3_i == 3'b101) ctrl_c = ALU_SRA;
            end
`ifdef ALU_MEXT_EN
            else if (Funct7_i == FUNCT7_MEXT) begin
               ctrl_c = mext_op(Funct3_i);
            end
`endif
         end
         ALUOP_MEM: ctrl_c = ALU_ADD;
         ALUOP_LUI: ctrl_c = ALU_PASSB;
         default:   ctrl_c = base_op(Funct3_i, Funct7_i[5]);
      endcase
   end

   // Single-cycle integer ALU; anything not listed computes AND
   always_comb begin
      case (ctrl_c)
         ALU_ADD:   alu_res_c = OperandA_i + OperandB_i;
         ALU_SUB:   alu_res_c = OperandA_i - OperandB_i;
         ALU_SLL:   alu_res_c = OperandA_i << shamt_c;
         ALU_SLT:   alu_res_c = {{(XLEN-1){1'b0}}, ($signed(OperandA_i) < $signed(OperandB_i))};
         ALU_SLTU:  alu_res_c = {{(XLEN-1){1'b0}}, (OperandA_i < OperandB_i)};
         ALU_XOR:   alu_res_c = OperandA_i ^ OperandB_i;
         ALU_SRL:   alu_res_c = OperandA_i >> shamt_c;
         ALU_SRA:   alu_res_c = $unsigned($signed(OperandA_i) >>> shamt_c);
         ALU_OR:    alu_res_c = OperandA_i | OperandB_i;
         ALU_PASSB: alu_res_c = OperandB_i;
         default:   alu_res_c = OperandA_i & OperandB_i;
      endcase
   end

`ifdef ALU_MEXT_EN
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   alu_state_e      state_q, state_d;
   logic            is_m_c, is_div_c, div_zero_c, div_ovf_c, special_c, start_c;
   logic            eng_done_c;
   logic [XLEN-1:0] spec_res_c;

   // Classify M ops and resolve divide-by-zero / signed overflow in one cycle
   always_comb begin
      is_m_c     = 1'b0;
      is_div_c   = 1'b0;
      spec_res_c = '0;
      case (ctrl_c)
         ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: is_m_c = 1'b1;
         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
            is_m_c   = 1'b1;
            is_div_c = 1'b1;
         end
         default: ;
      endcase
      div_zero_c = (OperandB_i == '0);
      div_ovf_c  = ((ctrl_c == ALU_DIV) || (ctrl_c == ALU_REM)) &&
                   (OperandA_i == SMIN) && (OperandB_i == '1);
      special_c  = is_div_c && (div_zero_c || div_ovf_c);
      if (div_zero_c) begin
         spec_res_c = ((ctrl_c == ALU_DIV) || (ctrl_c == ALU_DIVU)) ? '1 : OperandA_i;
      end else begin
         spec_res_c = (ctrl_c == ALU_DIV) ? OperandA_i : '0;
      end
      start_c   = accept_c && is_m_c && !special_c;
      single_c  = accept_c && !start_c;
      one_res_c = special_c ? spec_res_c : alu_res_c;
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // FSM next state: start an iterative op, leave on completion or flush
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_c) state_d = is_div_c ? DIV : MUL;
         MUL, DIV: if (flush_i || eng_done_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ready_o    = (state_q == IDLE);
   assign eng_fire_c = (state_q != IDLE) && eng_done_c && !flush_i;

   alu_muldiv_seq #(
      .XLEN(XLEN)
   ) u_muldiv (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start_i  (start_c),
      .run_i    (state_q != IDLE),
      .op_i     (ctrl_c),
      .a_i      (OperandA_i),
      .b_i      (OperandB_i),
      .done_c   (eng_done_c),
      .result_c (eng_res_c)
   );
`else
   assign ready_o    = 1'b1;
   assign single_c   = accept_c;
   assign one_res_c  = alu_res_c;
   assign eng_fire_c = 1'b0;
   assign eng_res_c  = '0;
`endif

   // Output selection: engine completion or a single-cycle accept, else hold
   always_comb begin
      result_d = result_q;
      valid_d  = 1'b0;
      if (eng_fire_c) begin
         result_d = eng_res_c;
         valid_d  = 1'b1;
      end else if (single_c) begin
         result_d = one_res_c;
         valid_d  = 1'b1;
      end
   end

   // Output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign result_o = result_q;
   assign valid_o  = valid_q;

endmodule
